// File: rtl/decoder_rr_arbiter.sv
// Round-robin owner selection for a shared 2-to-4 decoded select resource.
// Grants one requester at a time with a bounded hold time and a preempt pulse on forced release.
module decoder_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       preempt
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] HOLD_SAT  = {CNT_W{1'b1}};

  state_t           state;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] hold_cnt;
  logic [1:0]       winner_c;
  logic             timeout_c;

  // 2-to-4 decode of an owner index into its one-hot select
  function automatic logic [3:0] decode(input logic [1:0] idx);
    return {idx[1] & idx[0], idx[1] & ~idx[0], ~idx[1] & idx[0], ~idx[1] & ~idx[0]};
  endfunction

  // Lowest offset from ptr wins; scanning downward lets offset 0 overwrite last
  always_comb begin
    winner_c = ptr;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) winner_c = ptr + 2'(k);
    end
  end

  assign timeout_c = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= 4'b0000;
      gnt_idx   <= 2'd0;
      gnt_valid <= 1'b0;
      preempt   <= 1'b0;
      ptr       <= 2'd0;
      hold_cnt  <= '0;
    end else begin
      preempt <= 1'b0;
      case (state)
        IDLE: begin
          if (req != 4'b0000) begin
            state     <= GRANT;
            gnt_idx   <= winner_c;
            gnt       <= decode(winner_c);
            gnt_valid <= 1'b1;
            hold_cnt  <= '0;
          end
        end
        GRANT: begin
          // Voluntary release outranks timeout so a coincident drop never preempts
          if (!req[gnt_idx]) begin
            state     <= IDLE;
            gnt       <= 4'b0000;
            gnt_valid <= 1'b0;
            ptr       <= gnt_idx + 2'd1;
          end else if (timeout_c) begin
            state     <= IDLE;
            gnt       <= 4'b0000;
            gnt_valid <= 1'b0;
            ptr       <= gnt_idx + 2'd1;
            preempt   <= 1'b1;
          end else if (hold_cnt != HOLD_SAT) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          gnt       <= 4'b0000;
          gnt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Bench for decoder_rr_arbiter: directed scenarios plus random requests against a cycle model.
module tb_decoder_rr_arbiter;

  localparam int unsigned MAX_HOLD = 8;
  localparam int unsigned CNT_W    = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  int errors = 0;
  int checks = 0;

  // Model: owner (-1 = none), rotation pointer, cycles granted so far, preempt flag
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;
  bit m_pre   = 1'b0;

  decoder_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt),
    .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .preempt(preempt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_held  = 0;
      m_pre   = 1'b0;
    end else begin
      m_pre = 1'b0;
      if (m_owner < 0) begin
        for (int k = 0; k < 4; k++) begin
          int i;
          i = (m_ptr + k) % 4;
          if (req[i] && m_owner < 0) begin
            m_owner = i;
            m_held  = 1;
          end
        end
      end else if (!req[m_owner]) begin
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
      end else if (MAX_HOLD != 0 && m_held == int'(MAX_HOLD)) begin
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
        m_pre   = 1'b1;
      end else begin
        m_held++;
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0] eg;
    eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    check("gnt", 32'(gnt), 32'(eg));
    check("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
    if (m_owner >= 0) check("gnt_idx", 32'(gnt_idx), 32'(m_owner));
    check("preempt", 32'(preempt), 32'(m_pre));
  end

  task automatic drive(input logic [3:0] v);
    @(posedge clk);
    #1 req = v;
  endtask

  task automatic settle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic wait_grant(output int idx);
    idx = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (gnt_valid) begin
        idx = int'(gnt_idx);
        break;
      end
    end
    if (idx < 0) begin
      checks++;
      errors++;
      $display("FAIL wait_grant: got no grant within 40 cycles at %0t", $time);
    end
  endtask

  task automatic count_hold(input int owner, output int cnt);
    cnt = 1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (gnt_valid && int'(gnt_idx) == owner) cnt++;
      else break;
    end
  endtask

  initial begin
    int a;
    int cnt;
    #2 rst = 1'b1;
    req = 4'hF;

    // T1: reset holds everything low even with all requests up
    repeat (2) @(negedge clk);
    check("t1_rst_gnt", 32'(gnt), 32'h0);
    check("t1_rst_valid", 32'(gnt_valid), 32'h0);
    check("t1_rst_preempt", 32'(preempt), 32'h0);
    #2 rst = 1'b0;
    @(negedge clk);
    check("t1_first_gnt", 32'(gnt), 32'b0001);
    drive(4'b0000);
    settle();

    // T2: single requester, then ptr lands just after it
    drive(4'b0100);
    settle();
    check("t2_gnt", 32'(gnt), 32'b0100);
    check("t2_idx", 32'(gnt_idx), 32'd2);
    drive(4'b0000);
    settle();
    check("t2_release", 32'(gnt), 32'h0);
    drive(4'hF);
    settle();
    check("t2_ptr3", 32'(gnt), 32'b1000);
    drive(4'b0000);
    settle();

    // T3: rotation with owners dropping after two cycles
    drive(4'hF);
    for (int e = 0; e < 5; e++) begin
      wait_grant(a);
      check("t3_order", 32'(a), 32'(e % 4));
      @(posedge clk);
      #1 req[a] = 1'b0;
      @(posedge clk);
      #1 req[a] = 1'b1;
    end
    drive(4'b0000);
    settle();

    // T4: timeout with two persistent requesters
    pulse_reset();
    drive(4'b0011);
    wait_grant(a);
    check("t4_first_owner", 32'(a), 32'd0);
    count_hold(a, cnt);
    check("t4_hold_len0", 32'(cnt), 32'd8);
    check("t4_preempt", 32'(preempt), 32'd1);
    check("t4_dead_cycle", 32'(gnt), 32'h0);
    @(negedge clk);
    check("t4_second_owner", 32'(gnt), 32'b0010);
    count_hold(1, cnt);
    check("t4_hold_len1", 32'(cnt), 32'd8);
    drive(4'b0000);
    settle();
    settle();

    // T5: request drops on the timeout edge
    pulse_reset();
    drive(4'b0001);
    wait_grant(a);
    repeat (7) @(posedge clk);
    #1 req = 4'b0000;
    @(negedge clk);
    check("t5_still_granted", 32'(gnt), 32'b0001);
    settle();
    check("t5_no_preempt", 32'(preempt), 32'h0);
    check("t5_released", 32'(gnt), 32'h0);
    drive(4'hF);
    settle();
    check("t5_ptr_next", 32'(gnt), 32'b0010);

    // T6: asynchronous reset mid-grant
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_async_gnt", 32'(gnt), 32'h0);
    check("t6_async_valid", 32'(gnt_valid), 32'h0);
    @(negedge clk);
    #2 rst = 1'b0;
    wait_grant(a);
    check("t6_restart_owner", 32'(a), 32'd0);

    // Random phase: sticky requests so that timeouts and releases both occur
    for (int c = 0; c < 500; c++) begin
      @(posedge clk);
      #1;
      case ($urandom_range(0, 7))
        0:       req = 4'($urandom);
        1:       req[$urandom_range(0, 3)] = ~req[$urandom_range(0, 3)];
        2:       req = 4'b0000;
        default: ;
      endcase
    end
    req = 4'b0000;
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
